// File: rtl/md_unit.sv
// RV32M multiply/divide unit: shift-add multiply and restoring divide, 32 iterations plus a DONE cycle.
// Define MD_UNIT_DIV_EN to build the divider; without it, divide ops finish at once and flag illegal.
module md_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1_data,
    input  logic [31:0] rs2_data,
    input  logic [4:0]  rd_addr_in,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_addr_out,
    output logic        illegal
);
    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
    state_t state, state_next;

    logic [1:0]  op;
    logic [4:0]  rd_q;
    logic [4:0]  cnt;
    logic [31:0] opb;
    logic [63:0] acc;
    logic        neg_res;
    logic        illegal_q;

    logic        sign_a, sign_b, a_neg, b_neg, last;
    logic [31:0] a_mag, b_mag;

    assign sign_a = funct3[2] ? ~funct3[0] : (funct3[1] ^ funct3[0]);
    assign sign_b = funct3[2] ? ~funct3[0] : (funct3[1:0] == 2'b01);
    assign a_neg  = sign_a & rs1_data[31];
    assign b_neg  = sign_b & rs2_data[31];
    assign a_mag  = a_neg ? (~rs1_data + 32'd1) : rs1_data;
    assign b_mag  = b_neg ? (~rs2_data + 32'd1) : rs2_data;
    assign last   = (cnt == 5'd31);

    // acc = {partial product high, multiplier shifting out of the low half}
    logic [32:0] mul_sum;
    logic [63:0] mul_next, mul_prod;
    logic [31:0] mul_result;
    assign mul_sum    = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opb} : 33'd0);
    assign mul_next   = {mul_sum, acc[31:1]};
    assign mul_prod   = neg_res ? (~mul_next + 64'd1) : mul_next;
    assign mul_result = (op == 2'b00) ? mul_prod[31:0] : mul_prod[63:32];

`ifdef MD_UNIT_DIV_EN
    logic        div_zero, div_ovf, fast, neg_rem;
    logic [31:0] fast_res, quo, rem, div_result;
    logic [32:0] div_t, div_diff;
    logic [63:0] div_next;
    assign div_zero = (rs2_data == 32'd0);
    assign div_ovf  = ~funct3[0] && (rs1_data == 32'h8000_0000) && (rs2_data == 32'hFFFF_FFFF);
    assign fast     = div_zero | div_ovf;
    assign fast_res = div_zero ? (funct3[1] ? rs1_data : 32'hFFFF_FFFF)
                               : (funct3[1] ? 32'd0 : 32'h8000_0000);
    // acc = {remainder, dividend bits shifting out / quotient bits shifting in}
    assign div_t      = {acc[63:32], acc[31]};
    assign div_diff   = div_t - {1'b0, opb};
    assign div_next   = div_diff[32] ? {div_t[31:0], acc[30:0], 1'b0}
                                     : {div_diff[31:0], acc[30:0], 1'b1};
    assign quo        = neg_res ? (~div_next[31:0] + 32'd1) : div_next[31:0];
    assign rem        = neg_rem ? (~div_next[63:32] + 32'd1) : div_next[63:32];
    assign div_result = op[1] ? rem : quo;
`else
    logic        fast;
    logic [31:0] fast_res;
    assign fast     = 1'b1;
    assign fast_res = 32'd0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (!funct3[2])
                        state_next = MUL;
                    else if (fast)
                        state_next = DONE;
                    else
                        state_next = DIV;
                end
            end
            MUL, DIV: if (last) state_next = DONE;
            DONE:     state_next = IDLE;
            default:  state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op          <= 2'd0;
            rd_q        <= 5'd0;
            cnt         <= 5'd0;
            opb         <= 32'd0;
            acc         <= 64'd0;
            neg_res     <= 1'b0;
            illegal_q   <= 1'b0;
            result      <= 32'd0;
            rd_addr_out <= 5'd0;
`ifdef MD_UNIT_DIV_EN
            neg_rem     <= 1'b0;
`endif
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (start) begin
                        op      <= funct3[1:0];
                        rd_q    <= rd_addr_in;
                        cnt     <= 5'd0;
                        opb     <= b_mag;
                        acc     <= {32'd0, a_mag};
                        neg_res <= a_neg ^ b_neg;
`ifdef MD_UNIT_DIV_EN
                        neg_rem <= a_neg;
`endif
                        if (funct3[2] && fast) begin
                            result      <= fast_res;
                            rd_addr_out <= rd_addr_in;
`ifndef MD_UNIT_DIV_EN
                            illegal_q   <= 1'b1;
`endif
                        end
                    end
                end
                MUL: begin
                    acc <= mul_next;
                    cnt <= cnt + 5'd1;
                    if (last) begin
                        result      <= mul_result;
                        rd_addr_out <= rd_q;
                    end
                end
`ifdef MD_UNIT_DIV_EN
                DIV: begin
                    acc <= div_next;
                    cnt <= cnt + 5'd1;
                    if (last) begin
                        result      <= div_result;
                        rd_addr_out <= rd_q;
                    end
                end
`endif
                DONE:    illegal_q <= 1'b0;
                default: ;
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign done    = (state == DONE);
    assign illegal = illegal_q;
endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: vector table plus hand sequences, results checked by a done-driven scoreboard.
module tb_md_unit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1_data = 32'd0;
    logic [31:0] rs2_data = 32'd0;
    logic [4:0]  rd_addr_in = 5'd0;
    logic        busy, done, illegal;
    logic [31:0] result;
    logic [4:0]  rd_addr_out;

    md_unit dut (
        .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .rd_addr_in(rd_addr_in),
        .busy(busy), .done(done), .result(result), .rd_addr_out(rd_addr_out),
        .illegal(illegal)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] res;
        int          lat;
    } vec_t;

    typedef struct {
        int          id;
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
        int          due;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   extra_done = 0;
    int   op_id = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                extra_done++;
            end else begin
                mon_e = sb.pop_front();
                chk($sformatf("op%0d result", mon_e.id), result, mon_e.res);
                chk($sformatf("op%0d rd_addr_out", mon_e.id), {27'd0, rd_addr_out}, {27'd0, mon_e.rd});
                chk($sformatf("op%0d illegal", mon_e.id), {31'd0, illegal}, {31'd0, mon_e.ill});
                chk($sformatf("op%0d done_cycle", mon_e.id), cyc, mon_e.due);
            end
        end
    end

    // Latency counts cycles after the accept edge, so done in cycle N+lat lands at cyc == accept + lat - 1.
    task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] er, input int el, input logic ei);
        exp_t e;
        @(negedge clk);
        funct3 = f; rs1_data = a; rs2_data = b; rd_addr_in = rd; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        e.id = op_id; e.res = er; e.rd = rd; e.ill = ei; e.due = cyc + el - 1;
        op_id++;
        sb.push_back(e);
    endtask

    task automatic wait_done(input int exp_busy);
        int bc = 0;
        bit ok = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            #2;
            if (busy) bc++;
            if (sb.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL timeout: done not seen, %0d ops pending, required 0", sb.size());
            sb.delete();
        end else if (exp_busy >= 0) begin
            chk("busy_cycles", bc, exp_busy);
        end
    endtask

    vec_t        vecs [15];
    logic [31:0] er, ra, rb;
    logic [63:0] p;
    logic [2:0]  rf;
    logic        ei;
    int          el;

    initial begin
        vecs[0]  = '{3'd0, 32'd7,          32'd6,          5'd5,  32'd42,         33};
        vecs[1]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd1,  32'h0000_0000,  33};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  5'd2,  32'hFFFF_FFFE,  33};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'd2,          5'd3,  32'hFFFF_FFFF,  33};
        vecs[4]  = '{3'd0, 32'h1234_5678,  32'h10,         5'd0,  32'h2345_6780,  33};
        vecs[5]  = '{3'd1, 32'h8000_0000,  32'h8000_0000,  5'd31, 32'h4000_0000,  33};
        vecs[6]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,          5'd4,  32'hFFFF_FFFD,  33};
        vecs[7]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,          5'd6,  32'hFFFF_FFFF,  33};
        vecs[8]  = '{3'd5, 32'd100,        32'd7,          5'd8,  32'd14,         33};
        vecs[9]  = '{3'd7, 32'd100,        32'd7,          5'd10, 32'd2,          33};
        vecs[10] = '{3'd5, 32'd5,          32'd0,          5'd11, 32'hFFFF_FFFF,  1};
        vecs[11] = '{3'd6, 32'd5,          32'd0,          5'd12, 32'd5,          1};
        vecs[12] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF,  5'd13, 32'h8000_0000,  1};
        vecs[13] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF,  5'd14, 32'd0,          1};
        vecs[14] = '{3'd4, 32'd10,         32'd2,          5'd15, 32'd5,          33};

        repeat (3) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset done", {31'd0, done}, 32'd0);
        chk("reset illegal", {31'd0, illegal}, 32'd0);
        chk("reset result", result, 32'd0);
        chk("reset rd_addr_out", {27'd0, rd_addr_out}, 32'd0);
        rst_n = 1'b1;

        // Consecutive entries also exercise accept in the IDLE cycle right after DONE.
        for (int i = 0; i < 15; i++) begin
            er = vecs[i].res; el = vecs[i].lat; ei = 1'b0;
`ifndef MD_UNIT_DIV_EN
            if (vecs[i].f[2]) begin
                er = 32'd0; el = 1; ei = 1'b1;
            end
`endif
            issue(vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].rd, er, el, ei);
            wait_done(el);
        end

        for (int k = 0; k < 6; k++) begin
            ra = $urandom; rb = $urandom; rf = 3'($urandom_range(0, 3));
            case (rf)
                3'd1:    p = {{32{ra[31]}}, ra} * {{32{rb[31]}}, rb};
                3'd2:    p = {{32{ra[31]}}, ra} * {32'd0, rb};
                default: p = {32'd0, ra} * {32'd0, rb};
            endcase
            er = (rf == 3'd0) ? p[31:0] : p[63:32];
            issue(rf, ra, rb, 5'(k + 16), er, 33, 1'b0);
            wait_done(33);
        end

        // Second start mid-operation must be ignored entirely.
        issue(3'd0, 32'd7, 32'd6, 5'd5, 32'd42, 33, 1'b0);
        repeat (9) @(negedge clk);
        funct3 = 3'd0; rs1_data = 32'd1000; rs2_data = 32'd1000; rd_addr_in = 5'd9; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(-1);
        repeat (40) @(negedge clk);
        chk("ignored start no extra done", extra_done, 32'd0);

        // Reset mid-operation aborts with no done pulse.
        issue(3'd0, 32'd5, 32'd5, 5'd9, 32'd25, 33, 1'b0);
        repeat (14) @(negedge clk);
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset done", {31'd0, done}, 32'd0);
        chk("midreset result", result, 32'd0);
        chk("midreset rd_addr_out", {27'd0, rd_addr_out}, 32'd0);
        chk("midreset illegal", {31'd0, illegal}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        issue(3'd0, 32'd3, 32'd3, 5'd7, 32'd9, 33, 1'b0);
        wait_done(33);

        repeat (5) @(negedge clk);
        chk("no spurious done", extra_done, 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
